// File: rtl/joypad_poller.sv
// joypad_poller: polls a 4021-style serial joypad and publishes an
// active-high button word (bit0 A .. bit7 Right) plus a pad-present flag.
module joypad_poller #(
    parameter int unsigned PULSE_CYCLES = 6,
    parameter int unsigned POLL_CYCLES  = 30000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       poll_en,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad_data,
    output logic [7:0] btns,
    output logic       btns_valid,
    output logic       pad_present
);

    localparam int unsigned PHASE_W = $clog2(PULSE_CYCLES);
    localparam int unsigned INTV_W  = $clog2(POLL_CYCLES);
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned SHIFT_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    state_t               state;
    logic [PHASE_W-1:0]   phase;
    logic [IDX_W-1:0]     bit_idx;
    logic [SHIFT_W-1:0]   shift;
    logic [INTV_W-1:0]    interval;
    logic [1:0]           sync;
    logic                 ds;
    logic                 poll_start;
    logic                 phase_last;

    assign ds         = sync[1];
    assign phase_last = (phase == PHASE_W'(PULSE_CYCLES - 1));
    assign poll_start = (state == ST_IDLE) && poll_en && (interval == '0);

    // Two-flop synchronizer; idles high like an unplugged, pulled-up line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], pad_data};
        end
    end

    // Poll interval: reload on poll start, otherwise count down to zero and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval <= '0;
        end else if (poll_start) begin
            interval <= INTV_W'(POLL_CYCLES - 1);
        end else if (interval != '0) begin
            interval <= interval - INTV_W'(1);
        end
    end

    // Frame sequencer with registered pad strobes and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            phase       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b0;
            btns        <= 8'h00;
            btns_valid  <= 1'b0;
            pad_present <= 1'b0;
        end else begin
            // Strobes follow the state one cycle later so they stay glitch-free.
            pad_latch  <= (state == ST_LATCH);
            pad_clk    <= (state == ST_HIGH);
            btns_valid <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    phase <= '0;
                    if (poll_start) begin
                        shift <= '0;
                        state <= ST_LATCH;
                    end
                end

                ST_LATCH: begin
                    if (phase_last) begin
                        phase   <= '0;
                        bit_idx <= '0;
                        state   <= ST_LOW;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end

                // Sample late in the low phase so the synchronizer has settled.
                ST_LOW: begin
                    if (phase_last) begin
                        phase          <= '0;
                        shift[bit_idx] <= ~ds;
                        if (bit_idx == IDX_W'(SHIFT_W - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_HIGH;
                        end
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end

                ST_HIGH: begin
                    if (phase_last) begin
                        phase   <= '0;
                        bit_idx <= bit_idx + IDX_W'(1);
                        state   <= ST_LOW;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end

                // A real pad shifts in a low after its 8 buttons; a pulled-up
                // line reads high there, so captured bit 8 set means present.
                ST_DONE: begin
                    pad_present <= shift[8];
                    btns        <= shift[8] ? shift[7:0] : 8'h00;
                    btns_valid  <= 1'b1;
                    state       <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joypad_poller.sv
// Bench for joypad_poller: 4021 pad model, frame-timing monitor and a
// scoreboard of expected button words pushed at each latch strobe.
module tb_joypad_poller;

    localparam int unsigned T    = 4;
    localparam int unsigned POLL = 100;

    typedef struct packed {
        logic [7:0] btns;
        logic       present;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       poll_en = 1'b0;
    logic       pad_latch;
    logic       pad_clk;
    logic       pad_data;
    logic [7:0] btns;
    logic       btns_valid;
    logic       pad_present;

    // pad model configuration
    logic [7:0] pressed = 8'h09;
    logic       connected = 1'b1;
    logic       ninth = 1'b0;
    logic [8:0] sr = '1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    exp_t sb[$];

    // frame monitor results
    int o_lat_first, o_lat_last, o_lat_rises;
    int o_clk_pulses, o_clk_bad;
    int o_valid_at, o_valid_cnt, o_valid_double;

    joypad_poller #(.PULSE_CYCLES(T), .POLL_CYCLES(POLL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .poll_en     (poll_en),
        .pad_latch   (pad_latch),
        .pad_clk     (pad_clk),
        .pad_data    (pad_data),
        .btns        (btns),
        .btns_valid  (btns_valid),
        .pad_present (pad_present)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 4021: parallel load while latched, shift toward the output on pad_clk rise
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) sr <= {ninth, ~pressed};
        else           sr <= {ninth, sr[8:1]};
    end
    assign pad_data = connected ? sr[0] : 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected result of the frame that this latch strobe begins
    always @(posedge pad_latch) begin
        exp_t e;
        if (!connected || ninth) e = '{btns: 8'h00, present: 1'b0};
        else                     e = '{btns: pressed, present: 1'b1};
        sb.push_back(e);
    end

    always @(negedge clk) begin
        if (rst_n && btns_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_btns", 32'(btns), 32'(e.btns));
                check("sb_present", 32'(pad_present), 32'(e.present));
            end
        end
    end

    task automatic observe(input int ncyc);
        int rel, hi, lo;
        logic prev_clk, prev_lat, prev_val, seen_fall;
        o_lat_first = -1; o_lat_last = -1; o_lat_rises = 0;
        o_clk_pulses = 0; o_clk_bad = 0;
        o_valid_at = -1; o_valid_cnt = 0; o_valid_double = 0;
        hi = 0; lo = 0; seen_fall = 1'b0;
        prev_clk = pad_clk; prev_lat = pad_latch; prev_val = btns_valid;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (pad_latch) begin
                if (o_lat_first < 0) o_lat_first = rel;
                o_lat_last = rel;
                if (!prev_lat) o_lat_rises++;
            end
            if (pad_clk) begin
                if (!prev_clk) begin
                    if (seen_fall && lo != T) o_clk_bad++;
                    o_clk_pulses++;
                    hi = 0;
                end
                hi++;
            end else begin
                if (prev_clk) begin
                    if (hi != T) o_clk_bad++;
                    seen_fall = 1'b1;
                    lo = 0;
                end
                lo++;
            end
            if (btns_valid) begin
                if (o_valid_at < 0) o_valid_at = rel;
                o_valid_cnt++;
                if (prev_val) o_valid_double++;
            end
            prev_clk = pad_clk; prev_lat = pad_latch; prev_val = btns_valid;
        end
    endtask

    task automatic start_poll();
        @(negedge clk);
        poll_en = 1'b1;
        t0 = cyc + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_latch", 32'(pad_latch), 32'd0);
        check("rst_clk", 32'(pad_clk), 32'd0);
        check("rst_btns", 32'(btns), 32'd0);
        check("rst_valid", 32'(btns_valid), 32'd0);
        check("rst_present", 32'(pad_present), 32'd0);
        rst_n = 1'b1;

        // frame 1: A+Start, full timing check
        start_poll();
        observe(80);
        check("f1_latch_first", 32'(o_lat_first), 32'd1);
        check("f1_latch_last", 32'(o_lat_last), 32'(T));
        check("f1_clk_pulses", 32'(o_clk_pulses), 32'd8);
        check("f1_clk_widths", 32'(o_clk_bad), 32'd0);
        check("f1_valid_at", 32'(o_valid_at), 32'(18 * T + 1));

        // frame 2: button change between polls
        pressed = 8'h80;
        observe(100);
        check("f2_latch_first", 32'(o_lat_first), 32'(POLL + 1));
        check("f2_valid_at", 32'(o_valid_at), 32'(POLL + 18 * T + 1));

        // disconnected pad: two polls still report
        connected = 1'b0;
        observe(200);
        check("disc_valid_cnt", 32'(o_valid_cnt), 32'd2);
        check("disc_valid_at", 32'(o_valid_at), 32'(2 * POLL + 18 * T + 1));
        check("disc_latch_rises", 32'(o_lat_rises), 32'd2);
        check("disc_valid_double", 32'(o_valid_double), 32'd0);

        // poll_en dropped mid-frame
        poll_en = 1'b0;
        connected = 1'b1;
        pressed = 8'h01;
        do_reset();
        start_poll();
        observe(21);
        poll_en = 1'b0;
        observe(560);
        check("drop_valid_cnt", 32'(o_valid_cnt), 32'd1);
        check("drop_valid_at", 32'(o_valid_at), 32'(18 * T + 1));
        check("drop_latch_rises", 32'(o_lat_rises), 32'd0);
        start_poll();
        observe(80);
        check("reen_latch_first", 32'(o_lat_first), 32'd1);
        check("reen_valid_at", 32'(o_valid_at), 32'(18 * T + 1));

        // asynchronous reset in the middle of the next frame (pad_clk high)
        observe(62);
        check("pre_rst_clk", 32'(pad_clk), 32'd1);
        check("pre_rst_btns", 32'(btns), 32'h01);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_clk", 32'(pad_clk), 32'd0);
        check("arst_latch", 32'(pad_latch), 32'd0);
        check("arst_btns", 32'(btns), 32'd0);
        check("arst_present", 32'(pad_present), 32'd0);
        check("arst_valid", 32'(btns_valid), 32'd0);
        pressed = 8'h5A;
        repeat (3) @(negedge clk);
        check("arst_btns_hold", 32'(btns), 32'd0);
        rst_n = 1'b1;
        t0 = cyc + 1;
        observe(80);
        check("post_rst_latch_first", 32'(o_lat_first), 32'd1);
        check("post_rst_valid_at", 32'(o_valid_at), 32'(18 * T + 1));

        // all pressed, then a pad whose 9th bit reads high
        pressed = 8'hFF;
        observe(100);
        check("allp_valid_at", 32'(o_valid_at), 32'(POLL + 18 * T + 1));
        ninth = 1'b1;
        observe(100);
        check("ninth_valid_cnt", 32'(o_valid_cnt), 32'd1);

        poll_en = 1'b0;
        repeat (100) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/joypad_poller.md
# joypad_poller

Console-side initiator for a physical NES-style serial joypad port. It periodically drives the latch and clock lines of a 4021-style shift-register pad and samples the returned serial data. It assembles an 8-bit active-high button word and detects whether a pad is attached. It sits between the board's controller connector pins and the button inputs that the bench controller model otherwise supplies (A, B, Select, Start, Up, Down, Left, Right = bits 0..7).

## Interface
- PULSE_CYCLES, 6: T; width in clk cycles of latch high, each pad_clk high phase, and each pad_clk low phase; must be >= 4.
- POLL_CYCLES, 30000: clk cycles from one poll start to the next; must be >= 18*PULSE_CYCLES + 2.

- clk  in  1  block clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- poll_en  in  1  allow new polls; a frame already in progress always completes.
- pad_latch  out  1  latch/strobe to the pad, active-high, registered.
- pad_clk  out  1  shift clock to the pad, registered; the pad shifts on the rising edge.
- pad_data  in  1  raw serial data from the pad, asynchronous; low = pressed; the line is pulled high when no pad is attached.
- btns  out  8  last completed button word, active-high (bit0 A … bit7 Right).
- btns_valid  out  1  one-cycle pulse when btns/pad_present update.
- pad_present  out  1  pad detected on the last completed poll.

## Operation
- pad_data passes through a 2-flop synchronizer with reset value 1. All sampling uses the synchronizer output `ds`.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE. A phase counter (0..T-1), a bit index (0..8), and a 9-bit shift register are held in the FSM.
- Interval counter:
  - Loaded with POLL_CYCLES-1 on the cycle a poll starts.
  - Otherwise decrements each cycle, saturating at 0.
  - Reset value 0.
- IDLE → LATCH when poll_en=1 and interval=0. pad_latch=1 throughout LATCH.
- LATCH (T cycles) → LOW with bit index 0. pad_latch=0 and pad_clk=0.
- LOW (T cycles): on its last cycle, capture ~ds into shift bit [index].
  - index<8: → HIGH.
  - index=8: → DONE.
- HIGH (T cycles), pad_clk=1; on exit the index increments and the FSM → LOW.
- DONE (1 cycle):
  - pad_present = ~raw bit 8. A genuine pad shifts in 0 after 8 bits, so captured bit 8 = 1 means present.
  - btns = present ? captured bits[7:0] : 8'h00.
  - btns_valid=1.
  - → IDLE.
- poll_en deasserted mid-frame: the frame completes normally and no further poll starts.
- poll_en asserted while the interval counter is nonzero: the poll waits for the counter to reach 0.
- Reset mid-frame: all outputs return to reset values immediately and the frame is abandoned. There is no partial btns update.

## Timing
- Reset values:
  - pad_latch=0, pad_clk=0.
  - btns=8'h00, btns_valid=0, pad_present=0.
  - FSM=IDLE, interval=0, synchronizer=2'b11.
- Let cycle 0 be the first edge where IDLE sees poll_en=1 and interval=0. Then:
  - pad_latch is high for cycles 1..T.
  - Bit 0 is captured at cycle 2T.
  - pad_clk pulse k (k=1..8) is high for cycles (2k)T+1..(2k+1)T.
  - Bit k is captured at cycle (2k+2)T.
  - btns/pad_present/btns_valid are registered at cycle 18T+1.
  - Frame length: 18T+1 cycles plus the IDLE cycle.
- Capture is T-1 cycles after the preceding edge, so the 2-cycle synchronizer latency is absorbed for T≥4.
- Next poll start: cycle POLL_CYCLES, provided poll_en stays 1.
- btns holds its value between btns_valid pulses; btns_valid is never high for 2 consecutive cycles.

## Test plan
- Reset, then poll_en=1 with T=4, POLL_CYCLES=100, using a 4021 pad model with pressed=8'b0000_1001 (A+Start):
  - pad_latch high cycles 1–4.
  - 8 pad_clk pulses of 4 high / 4 low.
  - btns_valid pulses at cycle 73 with btns=8'h09, pad_present=1.
- Same pad, next frame: the second pad_latch rise is at cycle 101. Change pressed to 8'h80 before cycle 100 → the next btns_valid gives btns=8'h80.
- Pad disconnected (pad_data held 1) → btns=8'h00, pad_present=0, btns_valid still pulses every 100 cycles.
- poll_en dropped at cycle 20:
  - The frame completes with btns_valid at cycle 73.
  - No pad_latch rise for the next 500 cycles.
  - Re-raising poll_en restarts polling on the next edge (interval already 0).
- rst_n asserted at cycle 40 mid-frame:
  - All outputs go to reset values asynchronously; btns stays 8'h00.
  - After release a fresh frame starts and completes with correct data.
- Pad model returning all-pressed (pad_data 0 for 8 bits, then 0) → btns=8'hFF, pad_present=1. A pad variant whose 9th bit is 1 → btns=8'h00, pad_present=0.
